// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer / text-mode constants and types.
//   COLS, ROWS        text grid (character cells)
//   GLYPH_W, GLYPH_H  glyph cell size in pixels
//   FB_WIDTH          framebuffer line pitch in pixels
//   FB_HEIGHT         framebuffer height in lines
//   pixel_t           24-bit RGB pixel
//   fb_addr_t         16-bit framebuffer / text buffer address
//   blit_state_t      text_blitter FSM states
package fb_pkg;

    localparam int COLS      = 40;
    localparam int ROWS      = 25;
    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 8;
    localparam int FB_WIDTH  = COLS * GLYPH_W;
    localparam int FB_HEIGHT = ROWS * GLYPH_H;

    typedef logic [23:0] pixel_t;
    typedef logic [15:0] fb_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_CHAR,
        ST_WAIT_CHAR,
        ST_FETCH_GLYPH,
        ST_WAIT_GLYPH,
        ST_WRITE,
        ST_DONE
    } blit_state_t;

endpackage

// File: rtl/font_rom.sv
// font_rom: 128 glyphs x 8 rows x 8 bits, synchronous (registered) read.
//   clk  in   read clock
//   rst  in   asynchronous active-high reset (clears the output register)
//   adr  in   {glyph[6:0], row[2:0]}
//   q    out  glyph row byte, bit 7 = leftmost pixel, valid one cycle after adr
// The glyph table is held inline; codes without an entry render blank,
// which also covers 0x20 (space).
module font_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] adr,
    output logic [7:0] q
);

    logic [63:0] glyph;
    logic [7:0]  row_bits;

    // Each glyph is 8 bytes packed MSB-first: row 0 sits in bits [63:56].
    always_comb begin
        glyph = '0;
        case (adr[9:3])
            7'h20:   glyph = 64'h0000_0000_0000_0000;
            7'h30:   glyph = 64'h3C66_6E76_6666_3C00;
            7'h41:   glyph = 64'h183C_6666_7E66_6600;
            7'h42:   glyph = 64'h7C66_667C_6666_7C00;
            7'h43:   glyph = 64'h3C66_6060_6066_3C00;
            7'h48:   glyph = 64'h6666_667E_6666_6600;
            7'h7F:   glyph = 64'hFFFF_FFFF_FFFF_FFFF;
            default: glyph = '0;
        endcase
        // ~row == 7-row for a 3-bit row index
        row_bits = glyph[{~adr[2:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= row_bits;
    end

endmodule

// File: rtl/text_blitter.sv
// text_blitter: renders a COLS x ROWS text buffer through the 8x8 font ROM
// into the framebuffer, one 24-bit pixel per accepted write.
//   CLOCK_50   in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a frame (only honoured while idle)
//   fg, bg     in   colours, captured on the accepted start
//   busy       out  render in progress
//   done       out  one-cycle pulse after the last accepted pixel write
//   txt_adr    out  text buffer address (row*COLS+col)
//   txt        in   character code, valid one cycle after txt_adr
//   fb_wadr    out  pixel address
//   fb_d       out  pixel colour
//   fb_we      out  write request
//   fb_wready  in   write accepted when fb_we && fb_wready
module text_blitter #(
    parameter int COLS     = fb_pkg::COLS,
    parameter int ROWS     = fb_pkg::ROWS,
    parameter int FB_WIDTH = COLS * fb_pkg::GLYPH_W
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             start,
    input  fb_pkg::pixel_t   fg,
    input  fb_pkg::pixel_t   bg,
    output logic             busy,
    output logic             done,
    output fb_pkg::fb_addr_t txt_adr,
    input  logic [7:0]       txt,
    output fb_pkg::fb_addr_t fb_wadr,
    output fb_pkg::pixel_t   fb_d,
    output logic             fb_we,
    input  logic             fb_wready
);

    localparam fb_pkg::fb_addr_t PITCH     = fb_pkg::fb_addr_t'(FB_WIDTH);
    localparam fb_pkg::fb_addr_t ROW_STEP  = fb_pkg::fb_addr_t'(FB_WIDTH * fb_pkg::GLYPH_H);
    localparam fb_pkg::fb_addr_t CELL_STEP = fb_pkg::fb_addr_t'(fb_pkg::GLYPH_W);
    localparam logic [15:0]      LAST_COL  = 16'(COLS - 1);
    localparam logic [15:0]      LAST_ROW  = 16'(ROWS - 1);

    fb_pkg::blit_state_t state, state_nxt;

    fb_pkg::pixel_t   fg_q, bg_q;
    logic [7:0]       ch_q;
    logic [7:0]       glyph_q;
    logic [7:0]       rom_q;
    logic [9:0]       rom_adr;
    logic [2:0]       gx, gy;
    logic [15:0]      col, row;
    fb_pkg::fb_addr_t cell_idx;
    // Address bases kept as running sums so the pixel loop needs only adders:
    // row_base  = row*GLYPH_H*FB_WIDTH
    // cell_base = row_base + col*GLYPH_W
    // line_base = cell_base + gy*FB_WIDTH
    // pix_adr   = line_base + gx
    fb_pkg::fb_addr_t row_base, cell_base, line_base, pix_adr;
    fb_pkg::fb_addr_t next_cell_base;

    logic accept, last_px, last_gy, last_col, last_cell, px_on;

    assign accept    = (state == fb_pkg::ST_WRITE) && fb_wready;
    assign last_px   = (gx == 3'd7);
    assign last_gy   = (gy == 3'd7);
    assign last_col  = (col == LAST_COL);
    assign last_cell = last_col && (row == LAST_ROW);

    // First pixel of the next cell in row-major order; wrapping past the last
    // column lands on the start of the next band of GLYPH_H lines.
    assign next_cell_base = last_col ? (row_base + ROW_STEP) : (cell_base + CELL_STEP);

    assign rom_adr = {ch_q[6:0], gy};

    font_rom u_font (
        .clk (CLOCK_50),
        .rst (rst),
        .adr (rom_adr),
        .q   (rom_q)
    );

    assign txt_adr = cell_idx;
    assign fb_wadr = pix_adr;

    // char[7] selects inverse video for the whole cell.
    assign px_on = glyph_q[3'd7 - gx] ^ ch_q[7];
    assign fb_d  = fb_we ? (px_on ? fg_q : bg_q) : '0;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state <= fb_pkg::ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        fb_we     = 1'b0;
        case (state)
            fb_pkg::ST_IDLE: begin
                if (start) state_nxt = fb_pkg::ST_FETCH_CHAR;
            end
            fb_pkg::ST_FETCH_CHAR: begin
                busy      = 1'b1;
                state_nxt = fb_pkg::ST_WAIT_CHAR;
            end
            fb_pkg::ST_WAIT_CHAR: begin
                busy      = 1'b1;
                state_nxt = fb_pkg::ST_FETCH_GLYPH;
            end
            fb_pkg::ST_FETCH_GLYPH: begin
                busy      = 1'b1;
                state_nxt = fb_pkg::ST_WAIT_GLYPH;
            end
            fb_pkg::ST_WAIT_GLYPH: begin
                busy      = 1'b1;
                state_nxt = fb_pkg::ST_WRITE;
            end
            fb_pkg::ST_WRITE: begin
                busy  = 1'b1;
                fb_we = 1'b1;
                if (accept && last_px) begin
                    if (!last_gy)       state_nxt = fb_pkg::ST_FETCH_GLYPH;
                    else if (last_cell) state_nxt = fb_pkg::ST_DONE;
                    else                state_nxt = fb_pkg::ST_FETCH_CHAR;
                end
            end
            fb_pkg::ST_DONE: begin
                done      = 1'b1;
                state_nxt = fb_pkg::ST_IDLE;
            end
            default: state_nxt = fb_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            fg_q      <= '0;
            bg_q      <= '0;
            ch_q      <= '0;
            glyph_q   <= '0;
            gx        <= '0;
            gy        <= '0;
            col       <= '0;
            row       <= '0;
            cell_idx  <= '0;
            row_base  <= '0;
            cell_base <= '0;
            line_base <= '0;
            pix_adr   <= '0;
        end else begin
            case (state)
                fb_pkg::ST_IDLE: begin
                    if (start) begin
                        fg_q      <= fg;
                        bg_q      <= bg;
                        gx        <= '0;
                        gy        <= '0;
                        col       <= '0;
                        row       <= '0;
                        cell_idx  <= '0;
                        row_base  <= '0;
                        cell_base <= '0;
                        line_base <= '0;
                        pix_adr   <= '0;
                    end
                end
                fb_pkg::ST_WAIT_CHAR:  ch_q    <= txt;
                fb_pkg::ST_WAIT_GLYPH: glyph_q <= rom_q;
                fb_pkg::ST_WRITE: begin
                    // Nothing moves until the framebuffer takes the pixel.
                    if (accept) begin
                        if (!last_px) begin
                            gx      <= gx + 3'd1;
                            pix_adr <= pix_adr + 16'd1;
                        end else begin
                            gx <= '0;
                            if (!last_gy) begin
                                gy        <= gy + 3'd1;
                                line_base <= line_base + PITCH;
                                pix_adr   <= line_base + PITCH;
                            end else if (!last_cell) begin
                                gy        <= '0;
                                cell_idx  <= cell_idx + 16'd1;
                                cell_base <= next_cell_base;
                                line_base <= next_cell_base;
                                pix_adr   <= next_cell_base;
                                if (last_col) begin
                                    col      <= '0;
                                    row      <= row + 16'd1;
                                    row_base <= row_base + ROW_STEP;
                                end else begin
                                    col <= col + 16'd1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_blitter.sv
// Directed bench for text_blitter on a reduced 4x3 cell grid (32-pixel pitch)
// so that several complete frames fit in a short run.
module tb_text_blitter;

    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int FBW   = COLS * 8;
    localparam int NC    = COLS * ROWS;
    localparam int NPX   = NC * 64;
    localparam int FRAME = NC * 82;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] fg = '0, bg = '0;
    logic        busy, done;
    logic [15:0] txt_adr;
    logic [7:0]  txt = 8'h20;
    logic [15:0] fb_wadr;
    logic [23:0] fb_d;
    logic        fb_we;
    logic        fb_wready = 1'b1;

    text_blitter #(.COLS(COLS), .ROWS(ROWS), .FB_WIDTH(FBW)) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .start     (start),
        .fg        (fg),
        .bg        (bg),
        .busy      (busy),
        .done      (done),
        .txt_adr   (txt_adr),
        .txt       (txt),
        .fb_wadr   (fb_wadr),
        .fb_d      (fb_d),
        .fb_we     (fb_we),
        .fb_wready (fb_wready)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Text buffer: synchronous read, one cycle latency.
    logic [7:0] tbuf [NC];
    always @(posedge CLOCK_50) txt <= (int'(txt_adr) < NC) ? tbuf[txt_adr] : 8'h20;

    int total = 0, bad = 0;
    logic [23:0] cur_fg, cur_bg;
    int st_cyc;

    logic [15:0] wr_adr [$];
    logic [23:0] wr_dat [$];
    int          wr_cyc [$];
    int done_cnt = 0, done_cyc = 0, we_cnt = 0;

    always @(negedge CLOCK_50) begin
        if (fb_we === 1'b1) begin
            we_cnt++;
            if (fb_wready) begin
                wr_adr.push_back(fb_wadr);
                wr_dat.push_back(fb_d);
                wr_cyc.push_back(cyc);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] font_row(input logic [6:0] g, input int gy);
        logic [63:0] v;
        case (g)
            7'h41:   v = 64'h183C66667E666600;
            7'h42:   v = 64'h7C66667C66667C00;
            default: v = '0;
        endcase
        return v[63-8*gy -: 8];
    endfunction

    // Number of recorded writes that differ from the expected frame.
    function automatic int model_mismatches();
        int k = 0, n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int gy = 0; gy < 8; gy++)
                    for (int gx = 0; gx < 8; gx++) begin
                        logic [7:0]  ch;
                        logic [7:0]  bits;
                        logic [15:0] ea;
                        logic [23:0] ed;
                        ch   = tbuf[r*COLS+c];
                        bits = font_row(ch[6:0], gy);
                        ea   = 16'((r*8+gy)*FBW + c*8 + gx);
                        ed   = (bits[7-gx] ^ ch[7]) ? cur_fg : cur_bg;
                        if (k >= wr_adr.size()) n++;
                        else if (wr_adr[k] !== ea || wr_dat[k] !== ed) n++;
                        k++;
                    end
        if (wr_adr.size() > k) n += wr_adr.size() - k;
        return n;
    endfunction

    task automatic fill_blank();
        for (int i = 0; i < NC; i++) tbuf[i] = 8'h20;
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        wr_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
        we_cnt   = 0;
    endtask

    task automatic start_frame(input logic [23:0] f, input logic [23:0] b);
        cur_fg = f;
        cur_bg = b;
        @(posedge CLOCK_50); #1;
        fg = f;
        bg = b;
        start = 1'b1;
        @(negedge CLOCK_50);
        st_cyc = cyc;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_reset();
        int hi;
        bit found;
        #1 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (fb_we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%b want=0", fb_we); end
        total++; if (fb_wadr !== 16'd0) begin bad++; $display("FAIL reset_wadr got=%0d want=0", fb_wadr); end
        total++; if (fb_d !== 24'd0)    begin bad++; $display("FAIL reset_d got=%h want=0", fb_d); end
        total++; if (txt_adr !== 16'd0) begin bad++; $display("FAIL reset_txt_adr got=%0d want=0", txt_adr); end
        @(posedge CLOCK_50); #1 rst = 1'b0;

        // Reset asserted in the middle of a write burst.
        fill_blank();
        tbuf[0] = 8'h41;
        start_frame(24'hFFFFFF, 24'h000000);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK_50);
            if (fb_we === 1'b1 && fb_wadr === 16'd3) begin found = 1'b1; break; end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL midreset_reach got=%b want=1", found); end
        #2 rst = 1'b1;
        #1;
        total++; if (fb_we !== 1'b0)    begin bad++; $display("FAIL midreset_we got=%b want=0", fb_we); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        total++; if (fb_wadr !== 16'd0) begin bad++; $display("FAIL midreset_wadr got=%0d want=0", fb_wadr); end
        total++; if (fb_d !== 24'd0)    begin bad++; $display("FAIL midreset_d got=%h want=0", fb_d); end
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (fb_we !== 1'b0 || done !== 1'b0) hi++;
        end
        total++; if (hi !== 0) begin bad++; $display("FAIL reset_hold got=%0d active cycles want=0", hi); end
        @(posedge CLOCK_50); #1 rst = 1'b0;
    endtask

    task automatic test_single_cell();
        logic [23:0] r0 [8] = '{24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'h0};
        logic [23:0] r1 [8] = '{24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
        bit ok;
        int nz;
        fill_blank();
        tbuf[0] = 8'h41;
        clear_log();
        start_frame(24'hFFFFFF, 24'h000000);
        wait_done(FRAME + 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_done_seen got=%b want=1", ok); end
        total++; if (wr_adr.size() !== NPX) begin bad++; $display("FAIL single_count got=%0d want=%0d", wr_adr.size(), NPX); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_adr[i] !== 16'(i) || wr_dat[i] !== r0[i]) begin
                bad++; $display("FAIL single_row0[%0d] got=%0d/%h want=%0d/%h", i, wr_adr[i], wr_dat[i], i, r0[i]);
            end
            total++;
            if (wr_adr[8+i] !== 16'(FBW+i) || wr_dat[8+i] !== r1[i]) begin
                bad++; $display("FAIL single_row1[%0d] got=%0d/%h want=%0d/%h", i, wr_adr[8+i], wr_dat[8+i], FBW+i, r1[i]);
            end
        end
        nz = 0;
        for (int i = 64; i < 128; i++) if (wr_dat[i] !== 24'h0) nz++;
        total++; if (nz !== 0) begin bad++; $display("FAIL single_cell1_black got=%0d lit want=0", nz); end
        total++; if (model_mismatches() !== 0) begin bad++; $display("FAIL single_model got=%0d bad writes want=0", model_mismatches()); end
        total++; if (wr_cyc[NPX-1] - st_cyc !== FRAME) begin bad++; $display("FAIL single_frame_time got=%0d want=%0d", wr_cyc[NPX-1] - st_cyc, FRAME); end
        total++; if (done_cyc - st_cyc !== FRAME + 1) begin bad++; $display("FAIL single_done_cycle got=%0d want=%0d", done_cyc - st_cyc, FRAME + 1); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_inverse_last();
        localparam logic [23:0] F = 24'h123456;
        localparam logic [23:0] B = 24'hABCDEF;
        logic [23:0] r0 [8] = '{F, F, F, B, B, F, F, F};
        bit ok;
        int base;
        fill_blank();
        tbuf[5]    = 8'h42;
        tbuf[NC-1] = 8'hC1;
        clear_log();
        start_frame(F, B);
        wait_done(FRAME + 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL inv_done_seen got=%b want=1", ok); end
        total++; if (model_mismatches() !== 0) begin bad++; $display("FAIL inv_model got=%0d bad writes want=0", model_mismatches()); end
        base = NPX - 64;
        // Last cell (3,2): first line 16*32+24 = 536, last pixel 23*32+31 = 767.
        total++; if (wr_adr[base] !== 16'd536) begin bad++; $display("FAIL inv_first_adr got=%0d want=536", wr_adr[base]); end
        total++; if (wr_adr[NPX-1] !== 16'd767) begin bad++; $display("FAIL inv_last_adr got=%0d want=767", wr_adr[NPX-1]); end
        total++; if (wr_adr[NPX-8] !== 16'd760) begin bad++; $display("FAIL inv_lastrow_adr got=%0d want=760", wr_adr[NPX-8]); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_dat[base+i] !== r0[i]) begin
                bad++; $display("FAIL inv_row0[%0d] got=%h want=%h", i, wr_dat[base+i], r0[i]);
            end
        end
        total++; if (wr_dat[0] !== B) begin bad++; $display("FAIL inv_space_bg got=%h want=%h", wr_dat[0], B); end
    endtask

    task automatic test_stall();
        bit ok, found;
        fill_blank();
        tbuf[0] = 8'h41;
        clear_log();
        start_frame(24'hFFFFFF, 24'h000000);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLOCK_50); #1;
            if (fb_we === 1'b1 && fb_wadr === 16'd3) begin found = 1'b1; break; end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL stall_reach got=%b want=1", found); end
        fb_wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            total++; if (fb_wadr !== 16'd3 || fb_we !== 1'b1) begin bad++; $display("FAIL stall_hold_adr[%0d] got=%0d/%b want=3/1", i, fb_wadr, fb_we); end
            total++; if (fb_d !== 24'hFFFFFF) begin bad++; $display("FAIL stall_hold_d[%0d] got=%h want=ffffff", i, fb_d); end
            @(posedge CLOCK_50); #1;
        end
        fb_wready = 1'b1;
        wait_done(FRAME + 60, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_done_seen got=%b want=1", ok); end
        total++; if (model_mismatches() !== 0) begin bad++; $display("FAIL stall_model got=%0d bad writes want=0", model_mismatches()); end
        total++; if (wr_cyc[NPX-1] - st_cyc !== FRAME + 5) begin bad++; $display("FAIL stall_frame_time got=%0d want=%0d", wr_cyc[NPX-1] - st_cyc, FRAME + 5); end
        total++; if (done_cyc - st_cyc !== FRAME + 6) begin bad++; $display("FAIL stall_done_cycle got=%0d want=%0d", done_cyc - st_cyc, FRAME + 6); end
        total++; if (we_cnt !== NPX + 5) begin bad++; $display("FAIL stall_we_cycles got=%0d want=%0d", we_cnt, NPX + 5); end
    endtask

    task automatic test_start_busy();
        bit ok;
        for (int i = 0; i < NC; i++) tbuf[i] = (i % 2 == 0) ? 8'h41 : 8'h42;
        tbuf[3] = 8'hC2;
        clear_log();
        start_frame(24'h00FF00, 24'h0000FF);
        repeat (100) @(posedge CLOCK_50);
        #1 start = 1'b1;
        @(negedge CLOCK_50);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_during_frame got=%b want=1", busy); end
        @(posedge CLOCK_50); #1 start = 1'b0;
        wait_done(FRAME + 50, ok);
        repeat (20) @(posedge CLOCK_50);
        #1;
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", done_cnt); end
        total++; if (done_cyc - st_cyc !== FRAME + 1) begin bad++; $display("FAIL busy_done_cycle got=%0d want=%0d", done_cyc - st_cyc, FRAME + 1); end
        total++; if (we_cnt !== NPX) begin bad++; $display("FAIL busy_we_count got=%0d want=%0d", we_cnt, NPX); end
        total++; if (model_mismatches() !== 0) begin bad++; $display("FAIL busy_model got=%0d bad writes want=0", model_mismatches()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_restarted got=%b want=0", busy); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        fill_blank();
        tbuf[0] = 8'h41;
        tbuf[7] = 8'h42;
        clear_log();
        start_frame(24'hFF0000, 24'h00FF00);
        repeat (400) @(posedge CLOCK_50);
        @(negedge CLOCK_50); #2 rst = 1'b1;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50); #1 rst = 1'b0;
        repeat (20) @(posedge CLOCK_50);
        #1;
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
        clear_log();
        start_frame(24'hFF0000, 24'h00FF00);
        wait_done(FRAME + 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_done_seen got=%b want=1", ok); end
        total++; if (wr_adr[0] !== 16'd0) begin bad++; $display("FAIL abort_first_adr got=%0d want=0", wr_adr[0]); end
        total++; if (model_mismatches() !== 0) begin bad++; $display("FAIL abort_model got=%0d bad writes want=0", model_mismatches()); end
        total++; if (wr_cyc[NPX-1] - st_cyc !== FRAME) begin bad++; $display("FAIL abort_frame_time got=%0d want=%0d", wr_cyc[NPX-1] - st_cyc, FRAME); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_count got=%0d want=1", done_cnt); end
    endtask

    initial begin
        fill_blank();
        test_reset();
        test_single_cell();
        test_inverse_last();
        test_stall();
        test_start_busy();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
